// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_reg_chain_if
//  Brief    : Handshake bundle for pipe_reg_chain: upstream valid/ready/data,
//             downstream valid/ready/data, flush request and occupancy.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_reg_chain_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    // Environment side: produces input items and consumes output items.
    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    // Chain side.
    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_reg_chain
//  Brief    : Elastic chain of DEPTH enabled WIDTH-bit registers with per-stage
//             valid bits, valid/ready flow control, bubble collapse and a
//             synchronous flush. Stage 0 is the input side.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_reg_chain #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 2,
    parameter int RESET_DATA = 0,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_reg_chain_if.slave bus
);

    // Per-stage state.
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CNT_W-1:0] r_count;

    // Combinational flow-control terms.
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_src [DEPTH];
    logic             w_in_ready;
    logic             w_acc;

    // Advance terms, resolved from the output stage backwards: a stage moves
    // on when it holds an item and the slot ahead is empty or emptying.
    always_comb begin
        w_adv          = '0;
        w_adv[DEPTH-1] = r_valid[DEPTH-1] & bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = r_valid[i] & (~r_valid[i+1] | w_adv[i+1]);
        end
    end

    // Input acceptance; flush blocks any upstream handshake in its cycle.
    assign w_in_ready = ~bus.flush & (~r_valid[0] | w_adv[0]);
    assign w_acc      = bus.in_valid & w_in_ready;

    // Load enables and source data for each stage.
    always_comb begin
        w_load    = '0;
        w_load[0] = w_acc;
        w_src[0]  = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_load[i] = w_adv[i-1];
            w_src[i]  = r_data[i-1];
        end
    end

    // Valid bits: a load sets the bit (covers a simultaneous move-in/move-out),
    // an advance without a refill clears it.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~w_adv) | w_load;
        end
    end

    // Data registers are clock-enabled by the load term only.
    if (RESET_DATA != 0) begin : g_rst_data
        // Data cleared on reset and flush.
        always_ff @(posedge clk) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!rst_n || bus.flush) begin
                    r_data[i] <= '0;
                end else if (w_load[i]) begin
                    r_data[i] <= w_src[i];
                end
            end
        end
    end else begin : g_hold_data
        // Data keeps its contents through reset and flush.
        always_ff @(posedge clk) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rst_n && !bus.flush && w_load[i]) begin
                    r_data[i] <= w_src[i];
                end
            end
        end
    end

    // Occupancy tracks accepts minus completed output transfers.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_acc) - CNT_W'(w_adv[DEPTH-1]);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid[DEPTH-1];
    assign bus.out_data  = r_data[DEPTH-1];
    assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised, elastic chain of enabled data registers. It generalises the single enabled flop to DEPTH stages of WIDTH bits.
- Each stage carries its own valid bit. Flow control is a valid/ready handshake, with bubble collapse and a synchronous flush.
- Used to retime long datapaths between blocks without losing throughput under backpressure.

Parameters:
- WIDTH, 8: data width in bits, >=1.
- DEPTH, 2: number of register stages, >=1.
- RESET_DATA, 0: 1 = data registers clear to 0 on reset and flush; 0 = data registers have no reset and hold their contents.
- CNT_W, $clog2(DEPTH+1): width of the occupancy output (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous reset, active-low.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  chain can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  valid bit of stage DEPTH-1.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  data register of stage DEPTH-1.
- count  output  CNT_W  number of stages currently valid, 0..DEPTH.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- State: v[i] and d[i] for i = 0..DEPTH-1. Stage 0 is the input side.
- Advance terms (combinational):
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - adv[i] = v[i] & (~v[i+1] | adv[i+1]) for i < DEPTH-1.
- Ready: in_ready = ~flush & (~v[0] | adv[0]). The ready path is combinational through the chain; this is accepted by design.
- Accept condition: acc = in_valid & in_ready.
- Stage update, each posedge, in priority order:
  1. rst_n=0: all v=0; count=0; d=0 if RESET_DATA=1, otherwise d unchanged.
  2. flush=1: all v=0; count=0; d=0 if RESET_DATA=1, otherwise d unchanged. No handshake completes on either side: in_ready=0, and any downstream transfer in that cycle is discarded.
  3. Otherwise, for stage i:
     - If i==0 loads on acc, or i>0 loads on adv[i-1]: d[i] <= source data, v[i] <= 1.
     - Else if adv[i]: v[i] <= 0.
     - Else: hold v[i] and d[i].
- Data enable: d[i] is written only on the load condition, so it is clock-enabled and holds otherwise.
- Outputs: out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]. While out_valid=1 and out_ready=0, out_data and out_valid stay stable until the transfer completes.
- count: registered. Next value = count + acc - (adv[DEPTH-1] & ~flush); it becomes 0 on reset or flush. count always equals the popcount of v.
- Latency: an item accepted in cycle N appears on out_valid in cycle N+DEPTH when the chain has no stalls.
- Throughput: 1 item/clk when out_ready is held at 1.
- Bubble collapse: an empty stage is filled from the stage before it even while downstream is stalled. The chain therefore holds DEPTH items before in_ready drops.
- Full chain: all v=1 and out_ready=0 gives in_ready=0. All v=1 and out_ready=1 gives in_ready=1, a simultaneous push and pop with count unchanged.
- Ordering: strictly FIFO. No item is duplicated or dropped except by flush or reset.
- Reset mid-operation: all in-flight items are lost. Outputs are valid-low on the first cycle after the reset edge.
- DEPTH=1: degenerates to an enabled flop with valid/ready; in_ready = ~v[0] | out_ready.

Test Plan:
- WIDTH=8, DEPTH=3, out_ready=1; push 0x01..0x05 on consecutive cycles starting at cycle 0 -> out_valid first high at cycle 3 with 0x01, then 0x02..0x05 on consecutive cycles; count rises 1,2,3 and holds at 3 while streaming.
- DEPTH=3, out_ready=0, push 0xA0,0xA1,0xA2,0xA3 -> in_ready=0 after the third accept; count=3; out_data=0xA0 held. Raise out_ready -> 0xA0,0xA1,0xA2,0xA3 emerge in order with no gap.
- DEPTH=3, out_ready=0; push 0x11, idle 2 cycles, push 0x22 -> both collapse toward the output; count=2; in_ready stays 1; release outputs 0x11 then 0x22.
- count=2, in_valid=1, flush=1 for one cycle -> in_ready=0 during flush; next cycle count=0 and out_valid=0; the input item is not accepted.
- Full pipe, rst_n=0 for one cycle -> next cycle all outputs invalid and count=0; d=0 when RESET_DATA=1, d unchanged when RESET_DATA=0.
- DEPTH=1, out_ready=1, push 0x00..0x0F back-to-back -> each item out one cycle after accept; in_ready constantly 1. Toggle out_ready=0 -> in_ready drops the same cycle that v[0]=1.
